// File: rtl/segment_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module      : segment_collision_scanner
// Description : Stores up to DEPTH toolpath segments and scans one query
//               segment against every stored entry, one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_collision_scanner #(
    parameter int          W           = 8,
    parameter int          DEPTH       = 16,
    parameter int unsigned Z_TOL       = 0,
    parameter int          STOP_ON_HIT = 0,
    localparam int         IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [5*W-1:0]   load_seg,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [5*W-1:0]   q_seg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output logic [IW-1:0]    res_idx,
    output logic [IW:0]      res_count,
    output logic [IW:0]      count
);

    localparam logic [IW:0] c_DEPTH = (IW+1)'(DEPTH);
    localparam logic [IW:0] c_ONE   = (IW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    logic [5*W-1:0]   r_table [DEPTH];
    logic [5*W-1:0]   r_q;
    logic [IW:0]      r_count;
    logic [IW-1:0]    r_i;
    logic             r_acc_hit;
    logic [IW-1:0]    r_acc_idx;
    logic [IW:0]      r_acc_cnt;
    logic             r_res_valid;
    logic             r_res_hit;
    logic [IW-1:0]    r_res_idx;
    logic [IW:0]      r_res_count;

    // Sign of the cross product, 0 = collinear, 1 = positive, 2 = negative.
    function automatic logic [1:0] orient(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                          input logic [W-1:0] bx, input logic [W-1:0] by,
                                          input logic [W-1:0] cx, input logic [W-1:0] cy);
        logic signed [W:0]     d1, d2, d3, d4;
        logic signed [2*W+1:0] p1, p2;
        logic signed [2*W+2:0] cr;
        d1 = {1'b0, by} - {1'b0, ay};
        d2 = {1'b0, cx} - {1'b0, bx};
        d3 = {1'b0, bx} - {1'b0, ax};
        d4 = {1'b0, cy} - {1'b0, by};
        p1 = {{(W+1){d1[W]}}, d1} * {{(W+1){d2[W]}}, d2};
        p2 = {{(W+1){d3[W]}}, d3} * {{(W+1){d4[W]}}, d4};
        cr = {p1[2*W+1], p1} - {p2[2*W+1], p2};
        if (cr == '0)
            return 2'd0;
        else if (cr[2*W+2])
            return 2'd2;
        else
            return 2'd1;
    endfunction

    function automatic logic inbox(input logic [W-1:0] px, input logic [W-1:0] py,
                                   input logic [W-1:0] ax, input logic [W-1:0] ay,
                                   input logic [W-1:0] bx, input logic [W-1:0] by);
        return (px >= ((ax < bx) ? ax : bx)) && (px <= ((ax < bx) ? bx : ax)) &&
               (py >= ((ay < by) ? ay : by)) && (py <= ((ay < by) ? by : ay));
    endfunction

    logic [5*W-1:0] w_e;
    logic [W-1:0]   w_qx1, w_qy1, w_qx2, w_qy2, w_qz;
    logic [W-1:0]   w_ex1, w_ey1, w_ex2, w_ey2, w_ez;
    logic [1:0]     w_o1, w_o2, w_o3, w_o4;
    logic           w_xy;
    logic [W-1:0]   w_zd;
    logic           w_zok;
    logic           w_coll;
    logic [IW:0]    w_i_ext;
    logic           w_in_range;
    logic           w_hit_now;
    logic           w_last;
    logic           w_stop;
    logic           w_nhit;
    logic [IW-1:0]  w_nidx;
    logic [IW:0]    w_ncnt;
    logic           w_load_ready;
    logic           w_load_fire;

    assign w_e = r_table[r_i];
    assign {w_qx1, w_qy1, w_qx2, w_qy2, w_qz} = r_q;
    assign {w_ex1, w_ey1, w_ex2, w_ey2, w_ez} = w_e;

    always_comb begin
        w_o1  = orient(w_qx1, w_qy1, w_qx2, w_qy2, w_ex1, w_ey1);
        w_o2  = orient(w_qx1, w_qy1, w_qx2, w_qy2, w_ex2, w_ey2);
        w_o3  = orient(w_ex1, w_ey1, w_ex2, w_ey2, w_qx1, w_qy1);
        w_o4  = orient(w_ex1, w_ey1, w_ex2, w_ey2, w_qx2, w_qy2);
        w_xy  = ((w_o1 != w_o2) && (w_o3 != w_o4)) ||
                ((w_o1 == 2'd0) && inbox(w_ex1, w_ey1, w_qx1, w_qy1, w_qx2, w_qy2)) ||
                ((w_o2 == 2'd0) && inbox(w_ex2, w_ey2, w_qx1, w_qy1, w_qx2, w_qy2)) ||
                ((w_o3 == 2'd0) && inbox(w_qx1, w_qy1, w_ex1, w_ey1, w_ex2, w_ey2)) ||
                ((w_o4 == 2'd0) && inbox(w_qx2, w_qy2, w_ex1, w_ey1, w_ex2, w_ey2));
        w_zd  = (w_qz >= w_ez) ? (w_qz - w_ez) : (w_ez - w_qz);
        w_zok = (32'(w_zd) <= Z_TOL);
        w_coll = w_xy && w_zok;
    end

    // Scan bookkeeping: entries at or beyond count are never checked.
    assign w_i_ext    = {1'b0, r_i};
    assign w_in_range = (w_i_ext < r_count);
    assign w_hit_now  = w_in_range && w_coll;
    assign w_last     = ((w_i_ext + c_ONE) >= r_count);
    assign w_stop     = (STOP_ON_HIT != 0) && w_hit_now;
    assign w_nhit     = r_acc_hit | w_hit_now;
    assign w_nidx     = (!r_acc_hit && w_hit_now) ? r_i : r_acc_idx;
    assign w_ncnt     = (w_hit_now && (r_acc_cnt < c_DEPTH)) ? (r_acc_cnt + c_ONE) : r_acc_cnt;

    assign w_load_ready = (r_state == S_IDLE) && !q_valid && !clear && (r_count < c_DEPTH);
    assign w_load_fire  = load_valid && w_load_ready;

    always_ff @(posedge clk) begin
        if (w_load_fire)
            r_table[r_count[IW-1:0]] <= load_seg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_count     <= '0;
            r_i         <= '0;
            r_acc_hit   <= 1'b0;
            r_acc_idx   <= '0;
            r_acc_cnt   <= '0;
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_idx   <= '0;
            r_res_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (q_valid) begin
                        r_q       <= q_seg;
                        r_i       <= '0;
                        r_acc_hit <= 1'b0;
                        r_acc_idx <= '0;
                        r_acc_cnt <= '0;
                        r_state   <= S_SCAN;
                    end else if (clear) begin
                        r_count <= '0;
                    end else if (w_load_fire) begin
                        r_count <= r_count + c_ONE;
                    end
                end
                S_SCAN: begin
                    r_acc_hit <= w_nhit;
                    r_acc_idx <= w_nidx;
                    r_acc_cnt <= w_ncnt;
                    r_i       <= r_i + 1'b1;
                    if (w_last || w_stop) begin
                        r_res_valid <= 1'b1;
                        r_res_hit   <= w_nhit;
                        r_res_idx   <= w_nidx;
                        r_res_count <= w_ncnt;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_ready = w_load_ready;
    assign q_ready    = (r_state == S_IDLE);
    assign res_valid  = r_res_valid;
    assign res_hit    = r_res_hit;
    assign res_idx    = r_res_idx;
    assign res_count  = r_res_count;
    assign count      = r_count;

endmodule
`default_nettype wire
